// File: rtl/sargantana_icache_pkg.sv
// Shared icache types: fill arbiter state encoding, line type and line offset width.
package sargantana_icache_pkg;

  localparam int ICACHE_LINE_WIDTH       = 512;
  localparam int ICACHE_LINE_OFFSET_BITS = $clog2(ICACHE_LINE_WIDTH / 8);

  typedef logic [ICACHE_LINE_WIDTH-1:0] ifill_line_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DMD = 2'd1,
    WAIT_PF  = 2'd2,
    DRAIN    = 2'd3
  } fill_arb_state_t;

endpackage

// File: rtl/sargantana_icache_fill_arb.sv
// Single-outstanding iFill arbiter: demand over prefetch, demand-into-prefetch merge, flush drain.
// Optional watchdog enabled by defining ICACHE_FILL_WATCHDOG_EN.
module sargantana_icache_fill_arb
  import sargantana_icache_pkg::*;
#(
  parameter int PADDR_SIZE     = 40,
  parameter int LINE_WIDTH     = 512,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  dmd_req_valid_i,
  output logic                  dmd_req_ready_o,
  input  logic [PADDR_SIZE-1:0] dmd_req_paddr_i,
  input  logic                  pf_req_valid_i,
  output logic                  pf_req_ready_o,
  input  logic [PADDR_SIZE-1:0] pf_req_paddr_i,
  output logic                  dmd_resp_valid_o,
  output logic                  pf_resp_valid_o,
  output logic [LINE_WIDTH-1:0] resp_data_o,
  output logic [PADDR_SIZE-1:0] resp_paddr_o,
  output logic                  ifill_req_valid_o,
  output logic [PADDR_SIZE-1:0] ifill_req_paddr_o,
  input  logic                  ifill_resp_valid_i,
  input  logic                  ifill_resp_ack_i,
  input  logic [LINE_WIDTH-1:0] ifill_resp_data_i,
  output logic                  fill_timeout_o
);

  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  fill_arb_state_t       state_reg, state_next;
  logic [PADDR_SIZE-1:0] addr_reg, addr_next;
  logic                  dmd_resp_reg, pf_resp_reg;
  logic [LINE_WIDTH-1:0] resp_data_reg;
  logic [PADDR_SIZE-1:0] resp_paddr_reg;

  logic [PADDR_SIZE-1:0] dmd_aligned, pf_aligned;
  logic                  resp_ack, addr_hit, merge;
  logic                  dmd_fire, pf_fire, accept;

  assign dmd_aligned = {dmd_req_paddr_i[PADDR_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign pf_aligned  = {pf_req_paddr_i[PADDR_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign resp_ack    = ifill_resp_valid_i & ifill_resp_ack_i;
  assign addr_hit    = (dmd_aligned == addr_reg);
  assign merge       = (state_reg == WAIT_PF) & dmd_req_valid_i & addr_hit;

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    dmd_req_ready_o = 1'b0;
    pf_req_ready_o  = 1'b0;
    dmd_fire        = 1'b0;
    pf_fire         = 1'b0;
    accept          = 1'b0;
    case (state_reg)
      IDLE: begin
        dmd_req_ready_o = 1'b1;
        pf_req_ready_o  = ~dmd_req_valid_i;
        if (dmd_req_valid_i) begin
          state_next = WAIT_DMD;
          addr_next  = dmd_aligned;
          accept     = 1'b1;
        end else if (pf_req_valid_i) begin
          state_next = WAIT_PF;
          addr_next  = pf_aligned;
          accept     = 1'b1;
        end
      end
      WAIT_DMD: begin
        if (resp_ack) begin
          state_next = IDLE;
          dmd_fire   = ~flush_i;
        end else if (flush_i) begin
          state_next = DRAIN;
        end
      end
      WAIT_PF: begin
        // A merged demand reuses the in-flight upstream request for the same line.
        dmd_req_ready_o = addr_hit;
        accept          = merge;
        if (resp_ack) begin
          state_next = IDLE;
          dmd_fire   = ~flush_i & merge;
          pf_fire    = ~flush_i & ~merge;
        end else if (flush_i) begin
          state_next = DRAIN;
        end else if (merge) begin
          state_next = WAIT_DMD;
        end
      end
      DRAIN: begin
        if (resp_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      dmd_resp_reg   <= 1'b0;
      pf_resp_reg    <= 1'b0;
      resp_data_reg  <= '0;
      resp_paddr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      dmd_resp_reg <= dmd_fire;
      pf_resp_reg  <= pf_fire;
      if (dmd_fire | pf_fire) begin
        resp_data_reg  <= ifill_resp_data_i;
        resp_paddr_reg <= addr_reg;
      end
    end
  end

  assign ifill_req_valid_o = (state_reg != IDLE);
  assign ifill_req_paddr_o = addr_reg;
  assign dmd_resp_valid_o  = dmd_resp_reg;
  assign pf_resp_valid_o   = pf_resp_reg;
  assign resp_data_o       = resp_data_reg;
  assign resp_paddr_o      = resp_paddr_reg;

  // Offset bits never matter once addresses are line-aligned.
  logic unused_offset;
  assign unused_offset = ^{dmd_req_paddr_i[OFFSET_BITS-1:0], pf_req_paddr_i[OFFSET_BITS-1:0]};

`ifdef ICACHE_FILL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            timeout_reg;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else if (accept) begin
      wd_cnt_reg <= '0;
    end else if (state_reg != IDLE && wd_cnt_reg != WD_MAX) begin
      wd_cnt_reg <= wd_cnt_reg + 1'b1;
      if (wd_cnt_reg == WD_MAX - 1'b1) timeout_reg <= 1'b1;
    end
  end

  assign fill_timeout_o = timeout_reg;
`else
  logic unused_wd;
  assign unused_wd      = accept ^ (TIMEOUT_CYCLES != 0);
  assign fill_timeout_o = 1'b0;
`endif

endmodule
